// File: rtl/bp_fe_bht_driver_pkg.sv
// Shared types and constants for the BHT driver and its in-flight queue.
// The BP_DRIVER_STATS_EN build macro adds resolve/mispredict counters to the driver.
package bp_fe_bht_driver_pkg;

    localparam int unsigned bht_idx_width_gp = 9;
    localparam int unsigned vaddr_width_gp = 39;
    localparam int unsigned inflight_els_gp = 4;

    // PC bits below this offset are instruction-alignment bits
    localparam int unsigned idx_offset_lp = 2;

    localparam int unsigned stat_width_lp = 32;

    typedef struct packed {
        logic [bht_idx_width_gp-1:0] idx;
        logic                        pred;
    } bht_entry_s;

    function automatic int unsigned entry_width(input int unsigned idx_w);
        return idx_w + 1;
    endfunction

endpackage

// File: rtl/bp_fe_bht_inflight_fifo.sv
// In-order queue of outstanding BHT lookups.
// Pointer/count FIFO; flush clears pointers and count and overrides push/pop.
module bp_fe_bht_inflight_fifo
    import bp_fe_bht_driver_pkg::*;
#(
    parameter int unsigned width_p = entry_width(bht_idx_width_gp),
    parameter int unsigned els_p   = inflight_els_gp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned ptr_w = $clog2(els_p);
    localparam int unsigned cnt_w = ptr_w + 1;

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   head_r;
    logic [ptr_w-1:0]   tail_r;
    logic [cnt_w-1:0]   count_r;
    logic               push_v;
    logic               pop_v;

    assign full_o  = (count_r == cnt_w'(els_p));
    assign empty_o = (count_r == '0);
    assign push_v  = push_i & ~full_o & ~flush_i;
    assign pop_v   = pop_i & ~empty_o & ~flush_i;
    assign data_o  = mem[head_r];

    always_ff @(posedge clk_i) begin
        if (push_v) begin
            mem[tail_r] <= data_i;
        end
    end

    // els_p is a power of two, so pointers wrap naturally
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_v) begin
                tail_r <= tail_r + ptr_w'(1);
            end
            if (pop_v) begin
                head_r <= head_r + ptr_w'(1);
            end
            count_r <= count_r + cnt_w'(push_v) - cnt_w'(pop_v);
        end
    end

endmodule

// File: rtl/bp_fe_bht_driver.sv
// Initiator side of the BHT read/update interface with an in-order in-flight queue.
// Define BP_DRIVER_STATS_EN to add saturating resolve/mispredict counters.
module bp_fe_bht_driver
    import bp_fe_bht_driver_pkg::*;
#(
    parameter int unsigned bht_idx_width_p = bht_idx_width_gp,
    parameter int unsigned vaddr_width_p   = vaddr_width_gp,
    parameter int unsigned inflight_els_p  = inflight_els_gp
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       fetch_v_i,
    input  logic [vaddr_width_p-1:0]   fetch_pc_i,
    output logic                       fetch_ready_o,
    output logic                       fetch_predict_o,
    input  logic                       resolve_v_i,
    input  logic                       resolve_taken_i,
    input  logic                       flush_i,
    output logic                       r_v_o,
    output logic [bht_idx_width_p-1:0] idx_r_o,
    input  logic                       predict_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
`ifdef BP_DRIVER_STATS_EN
    output logic [stat_width_lp-1:0]   stat_resolves_o,
    output logic [stat_width_lp-1:0]   stat_mispredicts_o,
`endif
    output logic                       err_o
);

    localparam int unsigned idx_hi = bht_idx_width_p + idx_offset_lp - 1;
    localparam int unsigned ew     = entry_width(bht_idx_width_p);

    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       pred;
    } entry_s;

    entry_s push_entry;
    entry_s head_entry;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   upd;
    logic   upd_correct;
    logic   unused_pc;

    assign fetch_ready_o   = ~full;
    assign r_v_o           = fetch_v_i & fetch_ready_o;
    assign idx_r_o         = fetch_pc_i[idx_hi:idx_offset_lp];
    assign fetch_predict_o = predict_i;

    // Only the index field of the PC is looked at
    assign unused_pc = ^{fetch_pc_i[vaddr_width_p-1:idx_hi+1],
                         fetch_pc_i[idx_offset_lp-1:0]};

    assign push       = r_v_o;
    assign pop        = resolve_v_i & ~empty;
    assign upd        = pop & ~flush_i;
    assign push_entry = '{idx: idx_r_o, pred: predict_i};

    assign upd_correct = (head_entry.pred == resolve_taken_i);

    bp_fe_bht_inflight_fifo #(
        .width_p (ew),
        .els_p   (inflight_els_p)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .push_i    (push),
        .data_i    (push_entry),
        .pop_i     (pop),
        .data_o    (head_entry),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_o     <= 1'b0;
            idx_w_o   <= '0;
            correct_o <= 1'b0;
        end else begin
            w_v_o <= upd;
            if (upd) begin
                idx_w_o   <= head_entry.idx;
                correct_o <= upd_correct;
            end
        end
    end

    // Resolving with nothing outstanding is a protocol error; sticky until reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_o <= 1'b0;
        end else if (resolve_v_i & empty) begin
            err_o <= 1'b1;
        end
    end

`ifdef BP_DRIVER_STATS_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_resolves_o    <= '0;
            stat_mispredicts_o <= '0;
        end else if (upd) begin
            if (~&stat_resolves_o) begin
                stat_resolves_o <= stat_resolves_o + 1'b1;
            end
            if (!upd_correct && ~&stat_mispredicts_o) begin
                stat_mispredicts_o <= stat_mispredicts_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_bht_driver.sv
// Scoreboard bench for bp_fe_bht_driver.
// Define BP_DRIVER_STATS_EN to also check the statistics counters.
module tb_bp_fe_bht_driver;
    import bp_fe_bht_driver_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        fetch_v_i;
    logic [38:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic        fetch_predict_o;
    logic        resolve_v_i;
    logic        resolve_taken_i;
    logic        flush_i;
    logic        r_v_o;
    logic [8:0]  idx_r_o;
    logic        predict_i;
    logic        w_v_o;
    logic [8:0]  idx_w_o;
    logic        correct_o;
    logic        err_o;
`ifdef BP_DRIVER_STATS_EN
    logic [31:0] stat_resolves_o;
    logic [31:0] stat_mispredicts_o;
`endif

    typedef struct packed {
        logic [8:0] idx;
        logic       correct;
    } upd_s;

    bht_entry_s  mq[$];
    upd_s        exp_q[$];
    logic        m_err;
    int unsigned m_res;
    int unsigned m_mis;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_bht_driver dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .fetch_v_i          (fetch_v_i),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_ready_o      (fetch_ready_o),
        .fetch_predict_o    (fetch_predict_o),
        .resolve_v_i        (resolve_v_i),
        .resolve_taken_i    (resolve_taken_i),
        .flush_i            (flush_i),
        .r_v_o              (r_v_o),
        .idx_r_o            (idx_r_o),
        .predict_i          (predict_i),
        .w_v_o              (w_v_o),
        .idx_w_o            (idx_w_o),
        .correct_o          (correct_o),
`ifdef BP_DRIVER_STATS_EN
        .stat_resolves_o    (stat_resolves_o),
        .stat_mispredicts_o (stat_mispredicts_o),
`endif
        .err_o              (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every update pulse must match the oldest expected update
    always @(posedge clk_i) begin
        #1;
        if (reset_n_i && w_v_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_w_v", 64'(w_v_o), 64'd0);
            end else begin
                upd_s u;
                u = exp_q.pop_front();
                chk("idx_w", 64'(idx_w_o), 64'(u.idx));
                chk("correct", 64'(correct_o), 64'(u.correct));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        fetch_v_i = 1'b0;
        fetch_pc_i = '0;
        predict_i = 1'b0;
        resolve_v_i = 1'b0;
        resolve_taken_i = 1'b0;
        flush_i = 1'b0;
        mq.delete();
        exp_q.delete();
        m_err = 1'b0;
        m_res = 0;
        m_mis = 0;
        #1;
        chk("rst_w_v", 64'(w_v_o), 64'd0);
        chk("rst_idx_w", 64'(idx_w_o), 64'd0);
        chk("rst_correct", 64'(correct_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_ready", 64'(fetch_ready_o), 64'd1);
`ifdef BP_DRIVER_STATS_EN
        chk("rst_stat_res", 64'(stat_resolves_o), 64'd0);
        chk("rst_stat_mis", 64'(stat_mispredicts_o), 64'd0);
`endif
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic drive(input logic fv, input logic [38:0] pc,
                         input logic pd, input logic rv,
                         input logic rt, input logic fl);
        logic       can_push;
        bht_entry_s e;
        @(negedge clk_i);
        fetch_v_i = fv;
        fetch_pc_i = pc;
        predict_i = pd;
        resolve_v_i = rv;
        resolve_taken_i = rt;
        flush_i = fl;
        #1;
        can_push = (mq.size() < 4);
        chk("ready", 64'(fetch_ready_o), 64'(can_push));
        chk("r_v", 64'(r_v_o), 64'(fv && can_push));
        if (fv) begin
            chk("idx_r", 64'(idx_r_o), 64'(pc[10:2]));
            chk("fetch_predict", 64'(fetch_predict_o), 64'(pd));
        end
        if (rv && mq.size() == 0) m_err = 1'b1;
        if (fl) begin
            mq.delete();
        end else begin
            if (rv && mq.size() > 0) begin
                e = mq.pop_front();
                exp_q.push_back('{idx: e.idx, correct: (e.pred == rt)});
                m_res++;
                if (e.pred != rt) m_mis++;
            end
            if (fv && can_push) mq.push_back('{idx: pc[10:2], pred: pd});
        end
        @(posedge clk_i);
        #2;
        chk("err", 64'(err_o), 64'(m_err));
`ifdef BP_DRIVER_STATS_EN
        chk("stat_res", 64'(stat_resolves_o), 64'(m_res));
        chk("stat_mis", 64'(stat_mispredicts_o), 64'(m_mis));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0, 0);
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        do_reset();

        // single lookup then resolve taken
        drive(1, 39'h100, 1, 0, 0, 0);
        drive(0, '0, 0, 1, 1, 0);
        idle(2);

        // fill to full, blocked fetch, then four back-to-back resolves
        for (int i = 0; i < 4; i++)
            drive(1, 39'(32'h1000 + i * 4), 1, 0, 0, 0);
        drive(1, 39'h2000, 0, 0, 0, 0);
        drive(1, 39'h3000, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, '0, 0, 1, 0, 0);
        idle(2);

        // push and resolve together at count two
        drive(1, 39'h44, 0, 0, 0, 0);
        drive(1, 39'h48, 1, 0, 0, 0);
        drive(1, 39'h4c, 1, 1, 0, 0);
        chk("count_after_pushpop", 64'(mq.size()), 64'd2);
        drive(0, '0, 0, 1, 1, 0);
        drive(0, '0, 0, 1, 1, 0);
        idle(2);

        // flush at count three with concurrent fetch and resolve
        for (int i = 0; i < 3; i++)
            drive(1, 39'(32'h500 + i * 4), i[0], 0, 0, 0);
        drive(1, 39'h600, 1, 1, 1, 1);
        drive(0, '0, 0, 0, 0, 0);
        chk("ready_after_flush", 64'(fetch_ready_o), 64'd1);
        drive(0, '0, 0, 1, 0, 0);
        chk("err_after_flush", 64'(err_o), 64'd1);

        // sticky error across further valid traffic
        drive(1, 39'h7f4, 0, 0, 0, 0);
        drive(0, '0, 0, 1, 0, 0);
        idle(2);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)),
                  39'({$urandom(), $urandom()}),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0));
        end
        idle(3);

        // stats: 3 resolves, 1 wrong, then a flush
        do_reset();
        drive(1, 39'h10, 1, 0, 0, 0);
        drive(1, 39'h14, 0, 0, 0, 0);
        drive(1, 39'h18, 1, 0, 0, 0);
        drive(0, '0, 0, 1, 1, 0);
        drive(0, '0, 0, 1, 1, 0);
        drive(1, 39'h1c, 1, 1, 1, 0);
        drive(0, '0, 0, 0, 0, 1);
        idle(2);
        chk("final_err", 64'(err_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
